// File: rtl/sdmac_pkg.sv
// rtl/sdmac_pkg.sv - shared types and constants for the SCSI transfer sequencer
package sdmac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DMA_STRB,
    ST_CPU_STRB,
    ST_REC,
    ST_FLUSH_WR
  } seq_state_e;

  localparam logic [1:0] BO_LANE0 = 2'd0;
  localparam logic [1:0] BO_LANE3 = 2'd3;

  localparam logic DIR_S2F = 1'b0;
  localparam logic DIR_F2S = 1'b1;

  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_DMA = 1'b1;

endpackage

// File: rtl/sdmac_strobe_timer.sv
// rtl/sdmac_strobe_timer.sv - loadable 3-bit down-counter timing strobe and recovery phases
module sdmac_strobe_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic       zero
);

  logic [2:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= 3'd0;
    else if (load)
      cnt <= load_val;
    else if (cnt != 3'd0)
      cnt <= cnt - 3'd1;
  end

  assign zero = (cnt == 3'd0);

endmodule

// File: rtl/scsi_xfer_sequencer.sv
// rtl/scsi_xfer_sequencer.sv - arbitrates DMA and CPU access to the SCSI byte port and drives strobes/lanes
module scsi_xfer_sequencer
  import sdmac_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES   = 3,
  parameter int unsigned RECOVERY_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dmaena,
  input  logic dmadir,
  input  logic dreq_n,
  input  logic fifofull,
  input  logic fifoempty,
  input  logic flush,
  input  logic css_req,
  input  logic rw,
  output logic dack_n,
  output logic sior_n,
  output logic siow_n,
  output logic s2f,
  output logic f2s,
  output logic cpu2s,
  output logic s2cpu,
  output logic ls2cpu,
  output logic bo1,
  output logic bo0,
  output logic incfifo,
  output logic decfifo,
  output logic cpu_ack,
  output logic flushed
);

  localparam logic [2:0] STRB_LOAD = 3'(STROBE_CYCLES - 1);
  localparam logic [2:0] REC_LOAD  = 3'(RECOVERY_CYCLES - 1);

  seq_state_e state, nxt;
  logic [1:0] bo;
  logic       last_grant, byte_dir, dir_q;
  logic       inc_q, dec_q, ack_q;
  logic       tmr_load, tmr_zero;
  logic [2:0] tmr_val;
  logic       fifo_ok, dma_elig, cpu_elig, flush_req;

  sdmac_strobe_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // FIFO only gates the start of a new word; mid-word bytes go straight through
  assign fifo_ok   = (bo != BO_LANE0) || ((dmadir == DIR_S2F) ? !fifofull : !fifoempty);
  assign dma_elig  = dmaena && !dreq_n && fifo_ok;
  assign cpu_elig  = css_req;
  assign flush_req = flush && (dmadir == DIR_S2F);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt      = state;
    tmr_load = 1'b0;
    tmr_val  = STRB_LOAD;
    case (state)
      ST_IDLE: begin
        if (flush_req) begin
          if (bo != BO_LANE0)
            nxt = ST_FLUSH_WR;
        end else if (dma_elig && (!cpu_elig || last_grant == GRANT_CPU)) begin
          nxt      = ST_DMA_STRB;
          tmr_load = 1'b1;
        end else if (cpu_elig) begin
          nxt      = ST_CPU_STRB;
          tmr_load = 1'b1;
        end
      end
      ST_DMA_STRB, ST_CPU_STRB: begin
        if (tmr_zero) begin
          nxt      = ST_REC;
          tmr_load = 1'b1;
          tmr_val  = REC_LOAD;
        end
      end
      ST_REC:      if (tmr_zero) nxt = ST_IDLE;
      ST_FLUSH_WR: nxt = ST_IDLE;
      default:     nxt = ST_IDLE;
    endcase
  end

  // Byte offset, grant history and the REC-entry pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bo         <= BO_LANE0;
      last_grant <= GRANT_CPU;
      byte_dir   <= DIR_S2F;
      dir_q      <= DIR_S2F;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      dir_q <= dmadir;
      inc_q <= 1'b0;
      dec_q <= 1'b0;
      ack_q <= 1'b0;
      if (state == ST_IDLE && nxt == ST_DMA_STRB) begin
        last_grant <= GRANT_DMA;
        byte_dir   <= dmadir;
      end
      if (state == ST_IDLE && nxt == ST_CPU_STRB)
        last_grant <= GRANT_CPU;
      if (state == ST_DMA_STRB && nxt == ST_REC) begin
        bo    <= bo + 2'd1;
        inc_q <= (bo == BO_LANE3) && (byte_dir == DIR_S2F);
        dec_q <= (bo == BO_LANE3) && (byte_dir == DIR_F2S);
      end
      if (state == ST_CPU_STRB && nxt == ST_REC)
        ack_q <= 1'b1;
      if (nxt == ST_FLUSH_WR)
        bo <= BO_LANE0;
      // Switching direction mid-word abandons the partial word
      if (dmadir != dir_q && bo != BO_LANE0)
        bo <= BO_LANE0;
    end
  end

  always_comb begin
    dack_n  = 1'b1;
    sior_n  = 1'b1;
    siow_n  = 1'b1;
    s2f     = 1'b0;
    f2s     = 1'b0;
    cpu2s   = 1'b0;
    s2cpu   = 1'b0;
    ls2cpu  = 1'b0;
    incfifo = inc_q;
    decfifo = dec_q;
    cpu_ack = ack_q;
    flushed = 1'b0;
    case (state)
      ST_IDLE: flushed = flush_req && (bo == BO_LANE0);
      ST_DMA_STRB: begin
        dack_n = 1'b0;
        if (byte_dir == DIR_S2F) begin
          sior_n = 1'b0;
          s2f    = tmr_zero;
        end else begin
          siow_n = 1'b0;
          f2s    = 1'b1;
        end
      end
      ST_CPU_STRB: begin
        if (rw) begin
          sior_n = 1'b0;
          s2cpu  = 1'b1;
          ls2cpu = tmr_zero;
        end else begin
          siow_n = 1'b0;
          cpu2s  = 1'b1;
        end
      end
      ST_FLUSH_WR: begin
        incfifo = 1'b1;
        flushed = 1'b1;
      end
      default: ;
    endcase
  end

  assign bo1 = bo[1];
  assign bo0 = bo[0];

endmodule
